// File: rtl/bram_address_sequencer.sv
// ---------------------------------------------------------------------------
// bram_address_sequencer
//
// Burst address generator for the banked BRAM store. One command describes a
// block of rows (j range, wrapping modulo 2^J_SIZE), a column count (x from 0
// to x_last) and an interleave index i. The block then streams one
// (bram_number, bram_address) beat per cycle. The byte index changes fastest,
// then x, then j.
//
// Optional feature macro: ADDR_SEQ_BYTE_WALK_EN
//   defined     : the byte field walks 0 .. 2^DTYPE_BYTES_SIZE-1 per (j, x).
//   not defined : the byte field is held at 0, giving one beat per (j, x).
//
// Handshakes (both ports): a transfer happens on a rising clock edge where
// valid and ready are both high. The producer holds valid and its payload
// steady until that edge, and ready never depends combinationally on valid.
//
// Address mapping:
//   bram_number  = {i, j[BRAM_NUMBER_SIZE-I_SIZE-1:0]}  (just j bits if I_SIZE==0)
//   bram_address = {j[J_SIZE-1:BRAM_NUMBER_SIZE-I_SIZE], x, byte}
//
// dbg_state mirrors the FSM state register (0 = IDLE, 1 = RUN).
// ---------------------------------------------------------------------------
module bram_address_sequencer #(
  parameter int BRAM_NUMBER_SIZE  = 5,
  parameter int BRAM_ADDRESS_SIZE = 9,
  parameter int I_SIZE            = 1,
  parameter int J_SIZE            = 9,
  parameter int X_SIZE            = 3,
  parameter int DTYPE_BYTES_SIZE  = 1
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  // command port
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [((I_SIZE > 0) ? I_SIZE : 1)-1:0] cmd_i,
  input  logic [J_SIZE-1:0]                    cmd_j_start,
  input  logic [J_SIZE-1:0]                    cmd_j_last,
  input  logic [X_SIZE-1:0]                    cmd_x_last,
  // beat port
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [BRAM_NUMBER_SIZE-1:0]          out_bram_number,
  output logic [BRAM_ADDRESS_SIZE-1:0]         out_bram_address,
  output logic                                 out_last,
  // status
  output logic                                 busy,
  output logic                                 dbg_state
);

  // -------------------------------------------------------------------------
  // Derived widths and constants
  // -------------------------------------------------------------------------
  // Width of the i field as carried on the port (at least one bit).
  localparam int CI_W  = (I_SIZE > 0) ? I_SIZE : 1;
  // Number of j bits that land in the bank select.
  localparam int LOW_W = BRAM_NUMBER_SIZE - I_SIZE;
  // Number of j bits that land in the per-bank address.
  localparam int HI_W  = J_SIZE - LOW_W;
  // Byte counter width (at least one bit so the register always exists).
  localparam int B_W   = (DTYPE_BYTES_SIZE > 0) ? DTYPE_BYTES_SIZE : 1;
  // Left shift that places i above the j bits in the bank select.
  localparam int I_SHIFT = (I_SIZE > 0) ? LOW_W : 0;

  // Final value of the byte counter within one (j, x) element.
`ifdef ADDR_SEQ_BYTE_WALK_EN
  localparam logic [B_W-1:0] BYTE_MAX = B_W'((1 << DTYPE_BYTES_SIZE) - 1);
`else
  localparam logic [B_W-1:0] BYTE_MAX = '0;
`endif

  localparam logic [J_SIZE-1:0] J_ONE = J_SIZE'(1);
  localparam logic [X_SIZE-1:0] X_ONE = X_SIZE'(1);
  localparam logic [B_W-1:0]    B_ONE = B_W'(1);

  // -------------------------------------------------------------------------
  // Elaboration-time consistency checks on the parameter set
  // -------------------------------------------------------------------------
  if (BRAM_ADDRESS_SIZE != HI_W + X_SIZE + DTYPE_BYTES_SIZE) begin : g_addr_width_check
    $error("bram_address_sequencer: BRAM_ADDRESS_SIZE must equal J_SIZE-(BRAM_NUMBER_SIZE-I_SIZE)+X_SIZE+DTYPE_BYTES_SIZE");
  end
  if (LOW_W < 1 || HI_W < 1) begin : g_split_check
    $error("bram_address_sequencer: I_SIZE/BRAM_NUMBER_SIZE leave no j bits for bank or address");
  end
  if (I_SIZE < 0 || DTYPE_BYTES_SIZE < 0) begin : g_sign_check
    $error("bram_address_sequencer: I_SIZE and DTYPE_BYTES_SIZE must be non-negative");
  end

  // -------------------------------------------------------------------------
  // Mapping helpers
  // -------------------------------------------------------------------------
  // Bank select: interleave index on top, low j bits below.
  function automatic logic [BRAM_NUMBER_SIZE-1:0] bank_of(
    input logic [CI_W-1:0]   i,
    input logic [J_SIZE-1:0] j
  );
    logic [BRAM_NUMBER_SIZE-1:0] bn;
    bn = BRAM_NUMBER_SIZE'(j[LOW_W-1:0]);
    if (I_SIZE > 0) begin
      bn = bn | (BRAM_NUMBER_SIZE'(i) << I_SHIFT);
    end
    return bn;
  endfunction

  // Address within bank: high j bits, then x, then byte.
  function automatic logic [BRAM_ADDRESS_SIZE-1:0] addr_of(
    input logic [J_SIZE-1:0] j,
    input logic [X_SIZE-1:0] x,
    input logic [B_W-1:0]    b
  );
    logic [BRAM_ADDRESS_SIZE-1:0] a;
    a = BRAM_ADDRESS_SIZE'(j >> LOW_W) << (X_SIZE + DTYPE_BYTES_SIZE);
    a = a | (BRAM_ADDRESS_SIZE'(x) << DTYPE_BYTES_SIZE);
    // With DTYPE_BYTES_SIZE==0 the byte counter is pinned at 0, so this
    // contributes nothing.
    a = a | BRAM_ADDRESS_SIZE'(b);
    return a;
  endfunction

  // -------------------------------------------------------------------------
  // State and registers
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                        state_q;

  // Latched command fields.
  logic [CI_W-1:0]               i_q;
  logic [J_SIZE-1:0]             j_last_q;
  logic [X_SIZE-1:0]             x_last_q;

  // Coordinates of the beat currently presented on the output.
  logic [J_SIZE-1:0]             j_q;
  logic [X_SIZE-1:0]             x_q;
  logic [B_W-1:0]                byte_q;

  // Registered beat outputs.
  logic                          out_valid_q;
  logic                          out_last_q;
  logic [BRAM_NUMBER_SIZE-1:0]   bn_q;
  logic [BRAM_ADDRESS_SIZE-1:0]  addr_q;

  // Coordinates of the beat that follows the current one.
  logic [J_SIZE-1:0]             j_d;
  logic [X_SIZE-1:0]             x_d;
  logic [B_W-1:0]                byte_d;
  logic                          last_d;
  logic                          byte_wrap;
  logic                          x_wrap;

  // First-beat flag for an incoming command: single row, single column and
  // no byte walk beyond byte 0.
  logic                          first_last;

  // Beat handshake on the output side.
  logic                          beat_taken;

  assign beat_taken = out_valid_q & out_ready;

  // Next coordinates: byte rolls into x, x rolls into j (j wraps modulo 2^J_SIZE).
  always_comb begin
    byte_wrap = (byte_q == BYTE_MAX);
    x_wrap    = (x_q == x_last_q);
    byte_d    = byte_q;
    x_d       = x_q;
    j_d       = j_q;
    if (byte_wrap) begin
      byte_d = '0;
      if (x_wrap) begin
        x_d = '0;
        j_d = j_q + J_ONE;
      end else begin
        x_d = x_q + X_ONE;
      end
    end else begin
      byte_d = byte_q + B_ONE;
    end
    last_d = (j_d == j_last_q) & (x_d == x_last_q) & (byte_d == BYTE_MAX);
  end

  // Last-beat flag for the very first beat of a command being accepted now.
  always_comb begin
    first_last = (cmd_j_start == cmd_j_last) &
                 (cmd_x_last == '0) &
                 (BYTE_MAX == '0);
  end

  // Command/beat FSM with registered beat outputs and counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_last_q    <= '0;
      x_last_q    <= '0;
      j_q         <= '0;
      x_q         <= '0;
      byte_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      bn_q        <= '0;
      addr_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            // Latch the command and present its first beat next cycle.
            i_q         <= cmd_i;
            j_last_q    <= cmd_j_last;
            x_last_q    <= cmd_x_last;
            j_q         <= cmd_j_start;
            x_q         <= '0;
            byte_q      <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= first_last;
            bn_q        <= bank_of(cmd_i, cmd_j_start);
            addr_q      <= addr_of(cmd_j_start, '0, '0);
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (beat_taken) begin
            if (out_last_q) begin
              // Final beat consumed: burst complete.
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              // Advance to the next beat; outputs otherwise hold while stalled.
              j_q         <= j_d;
              x_q         <= x_d;
              byte_q      <= byte_d;
              out_last_q  <= last_d;
              bn_q        <= bank_of(i_q, j_d);
              addr_q      <= addr_of(j_d, x_d, byte_d);
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output assignments
  // -------------------------------------------------------------------------
  assign cmd_ready        = (state_q == ST_IDLE);
  assign busy             = (state_q != ST_IDLE);
  assign dbg_state        = state_q;
  assign out_valid        = out_valid_q;
  assign out_last         = out_last_q;
  assign out_bram_number  = bn_q;
  assign out_bram_address = addr_q;

endmodule

// File: tb/tb_bram_address_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bram_address_sequencer
//
// Directed bench for bram_address_sequencer with default parameters. Expected
// beats come from an arithmetic model of the address mapping and are queued
// when a command is driven; each accepted beat pops and compares one entry.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bram_address_sequencer;

  localparam int BN = 5;
  localparam int AW = 9;
  localparam int IS = 1;
  localparam int JS = 9;
  localparam int XS = 3;
  localparam int DS = 1;
`ifdef ADDR_SEQ_BYTE_WALK_EN
  localparam int NB = 1 << DS;
`else
  localparam int NB = 1;
`endif
  localparam int EW = 1 + BN + AW;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  always #5 clock = ~clock;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [IS-1:0] cmd_i;
  logic [JS-1:0] cmd_j_start;
  logic [JS-1:0] cmd_j_last;
  logic [XS-1:0] cmd_x_last;
  logic          out_valid;
  logic          out_ready;
  logic [BN-1:0] out_bram_number;
  logic [AW-1:0] out_bram_address;
  logic          out_last;
  logic          busy;
  logic          dbg_state;

  bram_address_sequencer dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_i            (cmd_i),
    .cmd_j_start      (cmd_j_start),
    .cmd_j_last       (cmd_j_last),
    .cmd_x_last       (cmd_x_last),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_bram_number  (out_bram_number),
    .out_bram_address (out_bram_address),
    .out_last         (out_last),
    .busy             (busy),
    .dbg_state        (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: enumerate every beat of a command in byte/x/j order.
  task automatic push_cmd(input int i, input int js, input int jl, input int xl);
    int rows, total, n, j, bn, addr;
    rows  = ((jl - js) & ((1 << JS) - 1)) + 1;
    total = rows * (xl + 1) * NB;
    n = 0;
    for (int r = 0; r < rows; r++) begin
      j = (js + r) & ((1 << JS) - 1);
      for (int x = 0; x <= xl; x++) begin
        for (int b = 0; b < NB; b++) begin
          bn   = ((i & ((1 << IS) - 1)) << (BN - IS)) | (j & ((1 << (BN - IS)) - 1));
          addr = ((j >> (BN - IS)) << (XS + DS)) | (x << DS) | b;
          n++;
          exp_q.push_back({(n == total), BN'(bn), AW'(addr)});
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive a command, wait for acceptance, land on the falling edge after it.
  task automatic send_cmd(input int i, input int js, input int jl, input int xl, input bit hold);
    int k;
    cmd_valid   = 1'b1;
    cmd_i       = IS'(i);
    cmd_j_start = JS'(js);
    cmd_j_last  = JS'(jl);
    cmd_x_last  = XS'(xl);
    push_cmd(i, js, jl, xl);
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (k >= 100) check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    if (!hold) cmd_valid = 1'b0;
    check("first_beat_valid", 32'(out_valid), 32'd1);
  endtask

  // Consume beats. mode 0: ready always, 1: ready 1,0,0 repeating, 2: random.
  // Returns after the last beat (or after stop_after beats if nonzero).
  task automatic drain(input int mode, input int stop_after, output int nbeats);
    bit            held;
    bit            done;
    logic [EW-1:0] hold_v;
    logic [EW-1:0] e;
    int            cyc;
    nbeats = 0;
    held   = 1'b0;
    done   = 1'b0;
    hold_v = '0;
    cyc    = 0;
    while (!done && cyc < 2000) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (held) check("stall_hold", 32'({out_valid, out_last, out_bram_number, out_bram_address}),
                      32'({1'b1, hold_v}));
      held = 1'b0;
      if (!out_valid) begin
        check("valid_in_run", 32'(out_valid), 32'd1);
        done = 1'b1;
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(exp_q.size()), 32'd1);
          done = 1'b1;
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'({out_last, out_bram_number, out_bram_address}), 32'(e));
          check("busy_ready_run", 32'({busy, cmd_ready, dbg_state}), 32'b101);
          nbeats++;
          if (e[EW-1] || nbeats == stop_after) done = 1'b1;
        end
      end else begin
        held   = 1'b1;
        hold_v = {out_last, out_bram_number, out_bram_address};
      end
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 2000) check("drain_timeout", 32'(cyc), 32'd0);
    out_ready = 1'b0;
    if (stop_after == 0) begin
      check("idle_after_last", 32'({out_valid, busy, cmd_ready, dbg_state}), 32'b0010);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int nb;
    cmd_valid   = 1'b0;
    cmd_i       = '0;
    cmd_j_start = '0;
    cmd_j_last  = '0;
    cmd_x_last  = '0;
    out_ready   = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    check("reset_outputs", 32'({out_valid, out_last, busy, cmd_ready, dbg_state}), 32'b00010);
    check("reset_bank_addr", 32'({out_bram_number, out_bram_address}), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic burst: i=1, j 0x13..0x14, x_last=1
    send_cmd(1, 'h013, 'h014, 1, 1'b0);
    check("t1_first_beat", 32'({out_bram_number, out_bram_address}), 32'({5'h13, 9'h010}));
    drain(0, 0, nb);
    check("t1_beat_count", 32'(nb), 32'(4 * NB));

    // Wrap through zero: i=0, j 0x1FF..0x000, x_last=0
    send_cmd(0, 'h1FF, 'h000, 0, 1'b0);
    check("t2_first_beat", 32'({out_bram_number, out_bram_address}), 32'({5'h0F, 9'h1F0}));
    drain(0, 0, nb);
    check("t2_beat_count", 32'(nb), 32'(2 * NB));

    // Backpressure 1,0,0 pattern on the basic burst
    send_cmd(1, 'h013, 'h014, 1, 1'b0);
    drain(1, 0, nb);
    check("t3_beat_count", 32'(nb), 32'(4 * NB));

    // Mid-burst reset after beat 3
    send_cmd(1, 'h013, 'h014, 1, 1'b0);
    drain(0, 3, nb);
    reset_n = 1'b0;
    #1;
    check("t4_reset_ctrl", 32'({out_valid, cmd_ready, busy, out_last}), 32'b0100);
    check("t4_reset_data", 32'({out_bram_number, out_bram_address}), 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("t4_no_more_beats", 32'(out_valid), 32'd0);
    send_cmd(1, 'h013, 'h014, 1, 1'b0);
    check("t4_restart_first", 32'({out_bram_number, out_bram_address}), 32'({5'h13, 9'h010}));
    drain(0, 0, nb);

    // Single row, single column; max x range
    send_cmd(1, 'h0A5, 'h0A5, 0, 1'b0);
    drain(0, 0, nb);
    check("single_row_count", 32'(nb), 32'(NB));
    send_cmd(0, 'h100, 'h100, 7, 1'b0);
    drain(2, 0, nb);
    check("max_x_count", 32'(nb), 32'(8 * NB));

    // cmd_valid held through RUN with changed fields; second command waits for IDLE
    send_cmd(1, 'h020, 'h021, 0, 1'b1);
    cmd_i       = 1'b0;
    cmd_j_start = 9'h1F0;
    cmd_j_last  = 9'h1F1;
    cmd_x_last  = 3'd2;
    push_cmd(0, 'h1F0, 'h1F1, 2);
    // Two commands' worth queued: drain the first, expecting its last beat.
    drain(0, -1, nb);
    check("t6_first_count", 32'(nb), 32'(2 * NB));
    check("t6_ready_in_idle", 32'({cmd_ready, busy}), 32'b10);
    @(negedge clock);
    cmd_valid = 1'b0;
    check("t6_second_accepted", 32'({out_valid, busy}), 32'b11);
    drain(1, 0, nb);
    check("t6_second_count", 32'(nb), 32'(6 * NB));

    // Random small commands with random backpressure
    for (int t = 0; t < 4; t++) begin
      int i_r, js_r, jl_r, xl_r;
      i_r  = int'($urandom_range(0, 1));
      js_r = int'($urandom_range(0, 511));
      jl_r = (js_r + int'($urandom_range(0, 2))) & 511;
      xl_r = int'($urandom_range(0, 7));
      send_cmd(i_r, js_r, jl_r, xl_r, 1'b0);
      drain(2, 0, nb);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog: reach the summary even if something wedges.
  initial begin
    #200000;
    tests_run++;
    tests_failed++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
